// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back byte cache: 8 blocks x 4 bytes, 3-bit tag, 32-bit block exchange with memory.
// Stalls the cpu with BUSYWAIT while a dirty victim is written back and/or the missing block is fetched.
module dcache_direct_mapped (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH} state_t;

    state_t      state_q;
    logic        issued_q;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [7:0]  readdata_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    logic [2:0] addr_tag;
    logic [2:0] addr_idx;
    logic [4:0] byte_lsb;
    logic       req;
    logic       store;
    logic       hit;
    logic       idle_hit;
    logic       xfer_done;
    logic [7:0] sel_byte;

    assign addr_tag  = ADDRESS[7:5];
    assign addr_idx  = ADDRESS[4:2];
    assign byte_lsb  = {ADDRESS[1:0], 3'b000};
    assign req       = READ | WRITE;
    assign store     = WRITE;
    assign hit       = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign idle_hit  = (state_q == S_IDLE) & req & hit;
    // The first edge after entering a transfer state only arms issued_q.
    assign xfer_done = issued_q & ~MEM_BUSYWAIT;
    assign sel_byte  = data_q[addr_idx][byte_lsb +: 8];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            issued_q   <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    issued_q <= 1'b0;
                    if (req && hit) begin
                        if (store) dirty_q[addr_idx] <= 1'b1;
                        else       readdata_q <= sel_byte;
                    end else if (req) begin
                        state_q <= (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    if (!issued_q) begin
                        issued_q <= 1'b1;
                    end else if (xfer_done) begin
                        issued_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!issued_q) begin
                        issued_q <= 1'b1;
                    end else if (xfer_done) begin
                        issued_q           <= 1'b0;
                        valid_q[addr_idx]  <= 1'b1;
                        dirty_q[addr_idx]  <= 1'b0;
                        state_q            <= S_IDLE;
                    end
                end
                default: begin
                    issued_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid_q gates their use.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (idle_hit && store) begin
                data_q[addr_idx][byte_lsb +: 8] <= WRITEDATA;
            end
            if (state_q == S_FETCH && xfer_done) begin
                data_q[addr_idx] <= MEM_READDATA;
                tag_q[addr_idx]  <= addr_tag;
            end
        end
    end

    assign BUSYWAIT      = (state_q == S_IDLE) ? (req & ~hit) : 1'b1;
    assign READDATA      = (idle_hit && !store) ? sel_byte : readdata_q;
    assign MEM_READ      = (state_q == S_FETCH);
    assign MEM_WRITE     = (state_q == S_WRITEBACK);
    assign MEM_ADDRESS   = (state_q == S_WRITEBACK) ? {tag_q[addr_idx], addr_idx} : ADDRESS[7:2];
    assign MEM_WRITEDATA = data_q[addr_idx];

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: latency-configurable block memory, byte-level reference memory,
// and a load scoreboard checked when BUSYWAIT releases the cpu.
module tb_dcache_direct_mapped;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = '0;
    logic [7:0]  WRITEDATA = '0;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache_direct_mapped dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Block memory: busy until the transfer has been visible for lat cycles.
    logic [31:0] mem [64];
    bit          mem_init_done = 1'b0;
    int          lat = 5;
    int          cnt = 0;
    bit          hold_busy = 1'b0;

    assign MEM_BUSYWAIT = hold_busy | ((MEM_READ | MEM_WRITE) & (cnt < lat - 1));
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= $urandom;
            mem[5] <= 32'hDDCCBBAA;
            mem_init_done <= 1'b1;
        end else if (MEM_READ || MEM_WRITE) begin
            if (!MEM_BUSYWAIT) begin
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Bus monitor: first write-back and first fetch seen since the last clear.
    bit          wb_seen = 1'b0;
    bit          fetch_seen = 1'b0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  fetch_addr = '0;

    always @(negedge CLK) begin
        chk("mem_rd_wr_exclusive", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
        if (MEM_WRITE && !wb_seen) begin
            wb_seen = 1'b1;
            wb_addr = MEM_ADDRESS;
            wb_data = MEM_WRITEDATA;
        end
        if (MEM_READ && !fetch_seen) begin
            fetch_seen = 1'b1;
            fetch_addr = MEM_ADDRESS;
        end
    end

    logic [7:0] exp_mem [256];
    logic [7:0] sb_q [$];

    task automatic rebuild_ref();
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 4; b++)
                exp_mem[i*4 + b] = mem[i][b*8 +: 8];
    endtask

    // Called just after a posedge; returns the number of stalled cycles.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output int stall);
        logic [7:0] exp;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        if (rd && !wr) sb_q.push_back(exp_mem[a]);
        if (wr) exp_mem[a] = wd;
        wb_seen = 1'b0;
        fetch_seen = 1'b0;
        stall = 0;
        @(negedge CLK);
        while (BUSYWAIT && stall < 60) begin
            stall++;
            @(negedge CLK);
        end
        if (stall >= 60) chk("busywait_timeout", 32'd1, 32'd0);
        if (rd && !wr) begin
            exp = sb_q.pop_front();
            chk("load_data", {24'd0, READDATA}, {24'd0, exp});
        end
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    int st;

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        chk("rst_readdata", {24'd0, READDATA}, 32'd0);
        RESET = 1'b1;
        rebuild_ref();

        // Cold read miss, then hit in the same block.
        lat = 5;
        access(1'b1, 1'b0, 8'h14, 8'h00, st);
        chk("miss_stall", st, 32'd6);
        chk("miss_fetch_addr", {26'd0, fetch_addr}, 32'h05);
        chk("miss_no_wb", {31'd0, wb_seen}, 32'd0);
        access(1'b1, 1'b0, 8'h17, 8'h00, st);
        chk("hit_stall", st, 32'd0);
        chk("hit_no_fetch", {31'd0, fetch_seen}, 32'd0);

        // Store hit, held READDATA, then conflicting miss with write-back.
        access(1'b0, 1'b1, 8'h15, 8'h5A, st);
        chk("store_hit_stall", st, 32'd0);
        @(negedge CLK);
        chk("readdata_hold", {24'd0, READDATA}, 32'hDD);
        @(posedge CLK); #1;
        access(1'b1, 1'b0, 8'h35, 8'h00, st);
        chk("wb_stall", st, 32'd11);
        chk("wb_addr", {26'd0, wb_addr}, 32'h05);
        chk("wb_data", wb_data, 32'hDDCC5AAA);
        chk("wb_fetch_addr", {26'd0, fetch_addr}, 32'h0D);

        // READ and WRITE together is a store: allocate then write.
        access(1'b1, 1'b1, 8'h00, 8'h77, st);
        chk("rw_alloc_stall", st, 32'd6);
        access(1'b1, 1'b0, 8'h00, 8'h00, st);
        chk("rw_readback_stall", st, 32'd0);
        access(1'b1, 1'b0, 8'h20, 8'h00, st);
        chk("rw_dirty_wb_stall", st, 32'd11);
        chk("rw_wb_addr", {26'd0, wb_addr}, 32'h00);
        chk("rw_wb_byte0", {24'd0, wb_data[7:0]}, 32'h77);

        // Memory that never stalls: two cycles per transfer state.
        lat = 1;
        access(1'b1, 1'b0, 8'h40, 8'h00, st);
        chk("fast_clean_stall", st, 32'd3);
        access(1'b0, 1'b1, 8'h41, 8'h99, st);
        access(1'b1, 1'b0, 8'h60, 8'h00, st);
        chk("fast_dirty_stall", st, 32'd5);
        chk("fast_wb_addr", {26'd0, wb_addr}, 32'h10);
        access(1'b0, 1'b1, 8'h0C, 8'hC3, st);
        chk("fast_store_miss_stall", st, 32'd3);

        // Reset during a stuck fetch abandons it and drops dirty block 3.
        lat = 5;
        hold_busy = 1'b1;
        READ = 1'b1; ADDRESS = 8'h48;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("stuck_mem_read", {31'd0, MEM_READ}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0; READ = 1'b0;
        @(posedge CLK); #1;
        chk("mid_rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("mid_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        RESET = 1'b1;
        hold_busy = 1'b0;
        @(posedge CLK); #1;
        rebuild_ref();
        access(1'b1, 1'b0, 8'h48, 8'h00, st);
        chk("post_rst_miss_stall", st, 32'd6);
        access(1'b1, 1'b0, 8'h0C, 8'h00, st);
        chk("post_rst_lost_dirty_stall", st, 32'd6);

        // Request dropped mid-miss: transfer finishes, cache idles.
        READ = 1'b1; ADDRESS = 8'hE4;
        repeat (2) @(posedge CLK); #1;
        READ = 1'b0;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        chk("drop_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("drop_mem_read", {31'd0, MEM_READ}, 32'd0);
        @(posedge CLK); #1;

        // Random mix over a few tags to force conflicts and write-backs.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            bit         w;
            lat = $urandom_range(1, 4);
            a = {$urandom_range(0, 2) == 0 ? 3'd0 : 3'($urandom_range(0, 7)), 5'($urandom)};
            w = ($urandom_range(0, 2) == 0);
            access(~w, w, a, 8'($urandom), st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
